control_fsm: RTL and testbench

- Multi-cycle RV32I sequencer. Drives every control signal of the core datapath from the current instruction opcode and the memory handshake.
- Sits between the instruction register decode (opcode, branch compare result) and the datapath strobes/muxes: PC, IR, register file, ALU input muxes and memory port.
- One instruction in flight. Fetch, dispatch, execute/memory, then return to fetch.

---
 rtl/control_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_control_fsm.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm -- multi-cycle RV32I sequencer.
//
// Runs one instruction at a time: fetch (PROLOGUE), dispatch on opcode,
// one execute state (plus a wait/writeback pair for loads and stores),
// then back to fetch.  Execute state codes equal the instr[6:2] opcode.
//
// Optional feature macro: CONTROL_FSM_TRAP_EN
//   defined   : an illegal opcode parks the FSM in HALT with trap=1 until reset
//   undefined : an illegal opcode retires as a no-op through MISCMEM, trap=0
//
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   opcode        instr[6:2] from the IR
//   cond          branch comparator result (1 = taken)
//   mem_complete  one-cycle pulse, current memory request finished
//   write_pc      PC load strobe;  next_pc_sel 0 = PC+4, 1 = ALU
//   write_ir      IR load strobe
//   write_rd      register file write;  rd_sel 00 ALU, 01 MEM, 10 PC+4
//   mem_read      memory read request (level)
//   mem_write     memory write request (level)
//   addr_sel      memory address 0 = ALU, 1 = PC
//   alu_insel1    00 RS1, 01 PC, 10 zero
//   alu_insel2    00 RS2, 01 immediate, 10 shamt
//   retire        instruction completes (same as write_pc)
//   trap          illegal-instruction flag, sticky until reset
module control_fsm #(
   parameter int OPCODE_WIDTH = 5,
   parameter int STATE_WIDTH  = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    cond,
   input  logic                    mem_complete,
   output logic                    write_pc,
   output logic                    next_pc_sel,
   output logic                    write_ir,
   output logic                    write_rd,
   output logic [1:0]              rd_sel,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic                    addr_sel,
   output logic [1:0]              alu_insel1,
   output logic [1:0]              alu_insel2,
   output logic                    retire,
   output logic                    trap
);

   typedef enum logic [STATE_WIDTH-1:0] {
      LOAD     = 5'b00000,
      LOAD_W   = 5'b00001,
      LOAD_1   = 5'b00010,
      MISCMEM  = 5'b00011,
      OPIMM    = 5'b00100,
      AUIPC    = 5'b00101,
      STORE    = 5'b01000,
      STORE_W  = 5'b01001,
      STORE_1  = 5'b01010,
      OP       = 5'b01100,
      LUI      = 5'b01101,
      BRANCH   = 5'b11000,
      JALR     = 5'b11001,
      JAL      = 5'b11011,
      SYSTEM   = 5'b11100,
      PROLOGUE = 5'b10000,
      DISPATCH = 5'b10001
`ifdef CONTROL_FSM_TRAP_EN
      ,
      HALT     = 5'b10010
`endif
   } state_t;

   state_t state;
   state_t dispatch_target;

   // Only real RV32I opcodes dispatch; the internal wait/writeback codes and
   // the PROLOGUE/DISPATCH/HALT codes are treated as illegal.
   always_comb begin
`ifdef CONTROL_FSM_TRAP_EN
      dispatch_target = HALT;
`else
      dispatch_target = MISCMEM;
`endif
      case (opcode)
         5'b01101: dispatch_target = LUI;
         5'b00101: dispatch_target = AUIPC;
         5'b11011: dispatch_target = JAL;
         5'b11001: dispatch_target = JALR;
         5'b11000: dispatch_target = BRANCH;
         5'b00000: dispatch_target = LOAD;
         5'b01000: dispatch_target = STORE;
         5'b00100: dispatch_target = OPIMM;
         5'b01100: dispatch_target = OP;
         5'b00011: dispatch_target = MISCMEM;
         5'b11100: dispatch_target = SYSTEM;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= PROLOGUE;
      end else begin
         case (state)
            PROLOGUE:       if (mem_complete) state <= DISPATCH;
            DISPATCH:       state <= dispatch_target;
            LOAD, LOAD_W:   state <= mem_complete ? LOAD_1 : LOAD_W;
            STORE, STORE_W: state <= mem_complete ? STORE_1 : STORE_W;
`ifdef CONTROL_FSM_TRAP_EN
            HALT:           state <= HALT;
`endif
            default:        state <= PROLOGUE;
         endcase
      end
   end

   // Outputs stay combinational: write_ir and the branch select must follow
   // mem_complete and cond within the same cycle.
   always_comb begin
      write_pc    = 1'b0;
      next_pc_sel = 1'b0;
      write_ir    = 1'b0;
      write_rd    = 1'b0;
      rd_sel      = '0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      addr_sel    = 1'b0;
      alu_insel1  = '0;
      alu_insel2  = '0;
      trap        = 1'b0;
      if (!rst) begin
         case (state)
            PROLOGUE: begin
               addr_sel = 1'b1;
               mem_read = 1'b1;
               write_ir = mem_complete;
            end
            LUI: begin
               alu_insel1 = 2'b10;
               alu_insel2 = 2'b01;
               write_rd   = 1'b1;
               write_pc   = 1'b1;
            end
            AUIPC: begin
               alu_insel1 = 2'b01;
               alu_insel2 = 2'b01;
               write_rd   = 1'b1;
               write_pc   = 1'b1;
            end
            OPIMM: begin
               alu_insel2 = 2'b01;
               write_rd   = 1'b1;
               write_pc   = 1'b1;
            end
            OP: begin
               write_rd = 1'b1;
               write_pc = 1'b1;
            end
            JAL: begin
               alu_insel1  = 2'b01;
               alu_insel2  = 2'b01;
               rd_sel      = 2'b10;
               write_rd    = 1'b1;
               next_pc_sel = 1'b1;
               write_pc    = 1'b1;
            end
            JALR: begin
               alu_insel2  = 2'b01;
               rd_sel      = 2'b10;
               write_rd    = 1'b1;
               next_pc_sel = 1'b1;
               write_pc    = 1'b1;
            end
            BRANCH: begin
               alu_insel1  = 2'b01;
               alu_insel2  = 2'b01;
               next_pc_sel = cond;
               write_pc    = 1'b1;
            end
            MISCMEM, SYSTEM: write_pc = 1'b1;
            LOAD, LOAD_W: begin
               alu_insel2 = 2'b01;
               mem_read   = 1'b1;
            end
            LOAD_1: begin
               rd_sel   = 2'b01;
               write_rd = 1'b1;
               write_pc = 1'b1;
            end
            STORE, STORE_W: begin
               alu_insel2 = 2'b01;
               mem_write  = 1'b1;
            end
            STORE_1: write_pc = 1'b1;
`ifdef CONTROL_FSM_TRAP_EN
            HALT: trap = 1'b1;
`endif
            default: ;
         endcase
      end
      retire = write_pc;
   end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

   localparam logic [4:0] OPC_LUI = 5'b01101, OPC_AUIPC = 5'b00101, OPC_JAL = 5'b11011,
                          OPC_JALR = 5'b11001, OPC_BR = 5'b11000, OPC_LOAD = 5'b00000,
                          OPC_STORE = 5'b01000, OPC_OPIMM = 5'b00100, OPC_OP = 5'b01100,
                          OPC_MISC = 5'b00011, OPC_SYS = 5'b11100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] opcode = 5'b0;
   logic       cond = 1'b0;
   logic       mem_complete = 1'b0;
   logic       write_pc, next_pc_sel, write_ir, write_rd, mem_read, mem_write, addr_sel;
   logic       retire, trap;
   logic [1:0] rd_sel, alu_insel1, alu_insel2;
   logic [14:0] dut_vec;

   int checks = 0;
   int errors = 0;

   control_fsm #(.OPCODE_WIDTH(5), .STATE_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .cond(cond), .mem_complete(mem_complete),
      .write_pc(write_pc), .next_pc_sel(next_pc_sel), .write_ir(write_ir),
      .write_rd(write_rd), .rd_sel(rd_sel), .mem_read(mem_read), .mem_write(mem_write),
      .addr_sel(addr_sel), .alu_insel1(alu_insel1), .alu_insel2(alu_insel2),
      .retire(retire), .trap(trap)
   );

   assign dut_vec = {write_pc, next_pc_sel, write_ir, write_rd, rd_sel, mem_read, mem_write,
                     addr_sel, alu_insel1, alu_insel2, retire, trap};

   always #5 clk = ~clk;

   // Memory responder: completes a request once it has been pending `lat` cycles.
   int unsigned lat = 0;
   int unsigned req_cnt = 0;
   logic extra_mc = 1'b0;
   logic req_prev = 1'b0, mc_prev = 1'b0;

   always @(negedge clk) begin
      req_prev = mem_read | mem_write;
      mc_prev  = mem_complete;
   end

   always @(posedge clk) begin
      #1;
      if (!req_prev || mc_prev) req_cnt = 0;
      else req_cnt++;
      mem_complete = ((mem_read | mem_write) && (req_cnt >= lat)) || extra_mc;
   end

   // Reference model: instruction phases and per-opcode control words.
   typedef enum {P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_HALT} phase_e;
   phase_e     ph = P_FETCH;
   logic [4:0] cur_op = 5'b0;

   function automatic bit is_legal(input logic [4:0] op);
      return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR, OPC_LOAD,
                        OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISC, OPC_SYS};
   endfunction

   function automatic logic [14:0] model_out(input phase_e p, input logic [4:0] op,
                                             input logic c, input logic mc);
      logic wpc, nps, wir, wrd, mrd, mwr, asel, trp;
      logic [1:0] rds, a1, a2;
      {wpc, nps, wir, wrd, mrd, mwr, asel, trp} = '0;
      rds = '0; a1 = '0; a2 = '0;
      case (p)
         P_FETCH: begin asel = 1'b1; mrd = 1'b1; wir = mc; end
         P_EXEC: begin
            wpc = 1'b1;
            case (op)
               OPC_LUI:   begin a1 = 2'd2; a2 = 2'd1; wrd = 1'b1; end
               OPC_AUIPC: begin a1 = 2'd1; a2 = 2'd1; wrd = 1'b1; end
               OPC_OPIMM: begin a2 = 2'd1; wrd = 1'b1; end
               OPC_OP:    wrd = 1'b1;
               OPC_JAL:   begin a1 = 2'd1; a2 = 2'd1; rds = 2'd2; wrd = 1'b1; nps = 1'b1; end
               OPC_JALR:  begin a2 = 2'd1; rds = 2'd2; wrd = 1'b1; nps = 1'b1; end
               OPC_BR:    begin a1 = 2'd1; a2 = 2'd1; nps = c; end
               default: ;
            endcase
         end
         P_MEM: begin
            a2 = 2'd1;
            if (op == OPC_LOAD) mrd = 1'b1;
            else mwr = 1'b1;
         end
         P_WB: begin
            wpc = 1'b1;
            if (op == OPC_LOAD) begin rds = 2'd1; wrd = 1'b1; end
         end
         P_HALT: trp = 1'b1;
         default: ;
      endcase
      return {wpc, nps, wir, wrd, rds, mrd, mwr, asel, a1, a2, wpc, trp};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         ph = P_FETCH;
      end else begin
         case (ph)
            P_FETCH: if (mem_complete) ph = P_DECODE;
            P_DECODE: begin
               cur_op = opcode;
               if (!is_legal(opcode)) begin
`ifdef CONTROL_FSM_TRAP_EN
                  ph = P_HALT;
`else
                  ph = P_EXEC;
`endif
               end else if (opcode == OPC_LOAD || opcode == OPC_STORE) ph = P_MEM;
               else ph = P_EXEC;
            end
            P_EXEC, P_WB: ph = P_FETCH;
            P_MEM: if (mem_complete) ph = P_WB;
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      logic [14:0] exp_v;
      exp_v = rst ? 15'd0 : model_out(ph, cur_op, cond, mem_complete);
      checks++;
      if (dut_vec !== exp_v) begin
         errors++;
         $display("FAIL model_cycle t=%0t phase=%0d: got %b required %b", $time, ph, dut_vec, exp_v);
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // Waits (bounded) for the next IR load, then presents the instruction.
   task automatic fetch(input logic [4:0] op, input logic c, output int waited);
      bit seen = 1'b0;
      waited = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         waited++;
         if (write_ir) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL fetch_timeout: no write_ir within %0d cycles, required within 40", waited);
      end
      #1;
      opcode = op;
      cond   = c;
   endtask

   logic [4:0] tab_op  [10] = '{OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP, OPC_JALR,
                                OPC_LOAD, OPC_STORE, OPC_MISC, OPC_SYS, OPC_BR};
   int         tab_gap [10] = '{3, 3, 3, 3, 3, 4, 4, 3, 3, 3};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cnt, ret_at;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_outputs", int'(dut_vec), 0);
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      chk("prologue_mem_read", mem_read, 1);
      chk("prologue_addr_sel", addr_sel, 1);

      // LUI, zero-wait memory
      lat = 0;
      fetch(OPC_LUI, 1'b0, n);
      chk("lui_c0_addr_sel", addr_sel, 1);
      @(negedge clk);
      chk("lui_c1_idle", int'(dut_vec), 0);
      @(negedge clk);
      chk("lui_c2_write_rd", write_rd, 1);
      chk("lui_c2_write_pc", write_pc, 1);
      chk("lui_c2_retire", retire, 1);
      chk("lui_c2_alu1", alu_insel1, 2);
      chk("lui_c2_alu2", alu_insel2, 1);

      // opcode table: fetch-to-fetch distances with zero-wait memory
      fetch(tab_op[0], 1'b0, n);
      chk("lui_next_fetch_gap", n, 1);
      for (int i = 1; i < 10; i++) begin
         fetch(tab_op[i], 1'($urandom_range(0, 1)), n);
         chk($sformatf("gap_op%05b", tab_op[i-1]), n, tab_gap[i-1]);
      end

      // LOAD completing on the third request cycle
      lat = 2;
      fetch(OPC_LOAD, 1'b0, n);
      cnt = 0; ret_at = -1;
      for (int c = 1; c <= 12 && ret_at < 0; c++) begin
         @(negedge clk);
         if (mem_read) cnt++;
         if (retire) begin
            ret_at = c;
            chk("load_wb_rd_sel", rd_sel, 1);
            chk("load_wb_write_rd", write_rd, 1);
            chk("load_wb_mem_read", mem_read, 0);
         end
      end
      chk("load_read_cycles", cnt, 3);
      chk("load_retire_cycle", ret_at, 5);

      // STORE with one wait cycle
      lat = 1;
      fetch(OPC_STORE, 1'b0, n);
      cnt = 0; ret_at = -1;
      for (int c = 1; c <= 12 && ret_at < 0; c++) begin
         @(negedge clk);
         if (mem_write) cnt++;
         if (retire) begin
            ret_at = c;
            chk("store_wb_write_rd", write_rd, 0);
            chk("store_wb_mem_write", mem_write, 0);
         end
      end
      chk("store_write_cycles", cnt, 2);
      chk("store_retire_cycle", ret_at, 4);

      // BRANCH not taken, then taken
      lat = 0;
      fetch(OPC_BR, 1'b0, n);
      repeat (2) @(negedge clk);
      chk("br0_next_pc_sel", next_pc_sel, 0);
      chk("br0_write_rd", write_rd, 0);
      chk("br0_write_pc", write_pc, 1);
      fetch(OPC_BR, 1'b1, n);
      repeat (2) @(negedge clk);
      chk("br1_next_pc_sel", next_pc_sel, 1);
      chk("br1_write_rd", write_rd, 0);
      chk("br1_alu1", alu_insel1, 1);

      // JAL with stray mem_complete pulses during dispatch/execute
      fetch(OPC_JAL, 1'b0, n);
      extra_mc = 1'b1;
      @(negedge clk);
      chk("dispatch_ignores_mc", int'(dut_vec), 0);
      @(negedge clk);
      chk("jal_rd_sel", rd_sel, 2);
      chk("jal_write_rd", write_rd, 1);
      chk("jal_next_pc_sel", next_pc_sel, 1);
      chk("jal_alu1", alu_insel1, 1);
      chk("jal_alu2", alu_insel2, 1);
      chk("jal_no_write_ir", write_ir, 0);
      #1 extra_mc = 1'b0;

      // reset pulse while a load is waiting on memory
      lat = 5;
      fetch(OPC_LOAD, 1'b0, n);
      repeat (3) @(negedge clk);
      chk("loadw_pending_read", mem_read, 1);
      #1 rst = 1'b1;
      #1 chk("rst_async_outputs", int'(dut_vec), 0);
      @(posedge clk); #2 rst = 1'b0;
      lat = 0;
      @(negedge clk);
      chk("post_rst_mem_read", mem_read, 1);
      chk("post_rst_addr_sel", addr_sel, 1);
      chk("post_rst_write_rd", write_rd, 0);

      // illegal opcode
      fetch(5'b11111, 1'b0, n);
      repeat (2) @(negedge clk);
`ifdef CONTROL_FSM_TRAP_EN
      chk("illegal_trap", trap, 1);
      chk("illegal_no_retire", retire, 0);
      repeat (5) @(negedge clk);
      chk("trap_sticky", trap, 1);
      chk("trap_no_fetch", mem_read, 0);
      #1 rst = 1'b1;
      #1 chk("trap_cleared_by_rst", trap, 0);
      @(posedge clk); #2 rst = 1'b0;
      fetch(OPC_LUI, 1'b0, n);
      repeat (2) @(negedge clk);
      chk("after_trap_lui_write_rd", write_rd, 1);
`else
      chk("illegal_write_pc", write_pc, 1);
      chk("illegal_retire", retire, 1);
      chk("illegal_next_pc_sel", next_pc_sel, 0);
      chk("illegal_write_rd", write_rd, 0);
      chk("illegal_trap_off", trap, 0);
      fetch(OPC_LUI, 1'b0, n);
      chk("illegal_next_fetch_gap", n, 1);
`endif
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
